dino_game_core: RTL and testbench

Gameplay core of the dinosaur runner. It debounces the 16 switches and the jump button, and runs the jump state machine that drives the dinosaur height and the game-running flag. It also scrolls the ground and ramps the speed, and generates the combinational ground pixel that the VGA block consumes per `row_addr`/`col_addr`. It sits between the board I/O and the VGA renderer.

---
 rtl/dino_game_core_if.sv | 23 ++
 rtl/dino_game_core.sv | 163 ++++++++++++++++
 tb/tb_dino_game_core.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dino_game_core_if.sv
// Board-side and VGA-side signal bundle of the dinosaur runner gameplay core.
// The slave modport is the core; the master modport is whatever drives it.
interface dino_game_core_if;
    logic        BTN_JUMP;
    logic [15:0] SW;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic [15:0] SW_OK;
    logic [5:0]  dinosaur_height;
    logic        game_status;
    logic [3:0]  speed;
    logic        px_ground;

    modport master (
        output BTN_JUMP, SW, row_addr, col_addr,
        input  SW_OK, dinosaur_height, game_status, speed, px_ground
    );

    modport slave (
        input  BTN_JUMP, SW, row_addr, col_addr,
        output SW_OK, dinosaur_height, game_status, speed, px_ground
    );
endinterface

// File: rtl/dino_game_core.sv
// Dinosaur runner gameplay core: input debouncing, game tick, jump FSM,
// ground scrolling with speed ramp and the combinational ground pixel.
module dino_game_core #(
    parameter int JITTER_BITS      = 4,
    parameter int TICK_CYCLES      = 1000000,
    parameter int JUMP_PEAK        = 40,
    parameter int SPEED_STEP_TICKS = 600,
    parameter int GROUND_ROW       = 400
) (
    input  logic            CLK,
    input  logic            RST,
    dino_game_core_if.slave bus
);
    localparam int CH  = 17;
    localparam int TW  = $clog2(TICK_CYCLES);
    localparam int STW = $clog2(SPEED_STEP_TICKS + 1);

    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [STW-1:0] STEP_LAST = STW'(SPEED_STEP_TICKS - 1);
    localparam logic [5:0]     PEAK_H    = 6'(JUMP_PEAK);
    localparam logic [8:0]     ROW_TOP   = 9'(GROUND_ROW);
    localparam logic [8:0]     ROW_SEC   = 9'(GROUND_ROW + 1);
    localparam logic [8:0]     ROW_DASH  = 9'(GROUND_ROW + 4);

    typedef enum logic [1:0] {GROUNDED, RISING, FALLING} jump_state_t;

    // Channel 16 is the jump button, channels 15..0 are the switches.
    logic [CH-1:0] raw_in;
    logic [CH-1:0] sync1_reg;
    logic [CH-1:0] sync2_reg;
    logic [CH-1:0] db_vec;

    assign raw_in = {bus.BTN_JUMP, bus.SW};

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_debounce
            logic                   db_reg;
            logic [JITTER_BITS-1:0] cnt_reg;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    db_reg  <= 1'b0;
                    cnt_reg <= '0;
                end else if (sync2_reg[gi] != db_reg) begin
                    if (&cnt_reg) begin
                        db_reg  <= sync2_reg[gi];
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + JITTER_BITS'(1);
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end

            assign db_vec[gi] = db_reg;
        end
    endgenerate

    logic [TW-1:0] tick_cnt_reg;
    logic          tick;

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge CLK) begin
        if (RST)
            tick_cnt_reg <= '0;
        else if (tick)
            tick_cnt_reg <= '0;
        else
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end

    jump_state_t    state_reg;
    logic [5:0]     height_reg;
    logic           status_reg;
    logic [3:0]     speed_reg;
    logic [9:0]     position_reg;
    logic [STW-1:0] step_reg;
    logic           btn_d_reg;
    logic           press;
    logic [10:0]    pos_sum;
    logic [9:0]     pos_next;

    assign press    = db_vec[CH-1] & ~btn_d_reg;
    assign pos_sum  = {1'b0, position_reg} + {7'd0, speed_reg};
    assign pos_next = (pos_sum >= 11'd640) ? 10'(pos_sum - 11'd640) : pos_sum[9:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= GROUNDED;
            height_reg   <= '0;
            status_reg   <= 1'b0;
            speed_reg    <= '0;
            position_reg <= '0;
            step_reg     <= '0;
            btn_d_reg    <= 1'b0;
        end else begin
            btn_d_reg <= db_vec[CH-1];
            if (press)
                status_reg <= 1'b1;
            // Ticks only scroll while running, so this never collides with the ramp below.
            if (press && !status_reg)
                speed_reg <= 4'd1;
            if (status_reg && tick) begin
                position_reg <= pos_next;
                if (step_reg == STEP_LAST) begin
                    step_reg <= '0;
                    if (speed_reg != 4'd15)
                        speed_reg <= speed_reg + 4'd1;
                end else begin
                    step_reg <= step_reg + STW'(1);
                end
            end
            case (state_reg)
                GROUNDED: begin
                    if (press)
                        state_reg <= RISING;
                end
                RISING: begin
                    if (tick) begin
                        height_reg <= height_reg + 6'd1;
                        if (height_reg + 6'd1 == PEAK_H)
                            state_reg <= FALLING;
                    end
                end
                FALLING: begin
                    if (tick) begin
                        height_reg <= height_reg - 6'd1;
                        if (height_reg == 6'd1)
                            state_reg <= GROUNDED;
                    end
                end
                default: state_reg <= GROUNDED;
            endcase
        end
    end

    // 640 is a multiple of 32, so the low five bits of the wrapped x need no wrap.
    logic [4:0] x_lo;

    assign x_lo = bus.col_addr[4:0] + position_reg[4:0];

    assign bus.px_ground = (bus.col_addr < 10'd640) &&
                           ((bus.row_addr == ROW_TOP) || (bus.row_addr == ROW_SEC) ||
                            ((bus.row_addr == ROW_DASH) && (x_lo < 5'd2)));

    assign bus.SW_OK           = db_vec[15:0];
    assign bus.dinosaur_height = height_reg;
    assign bus.game_status     = status_reg;
    assign bus.speed           = speed_reg;
endmodule

// File: tb/tb_dino_game_core.sv
// Randomized self-checking bench for dino_game_core against a behavioural
// model (tick count, jump progress and scroll sums kept as plain integers).
module tb_dino_game_core;
    localparam int JIT  = 4;
    localparam int TICK = 8;
    localparam int PEAK = 3;
    localparam int STEP = 2;
    localparam int GROW = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    dino_game_core_if bif();

    dino_game_core #(
        .JITTER_BITS(JIT), .TICK_CYCLES(TICK), .JUMP_PEAK(PEAK),
        .SPEED_STEP_TICKS(STEP), .GROUND_ROW(GROW)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [16:0] m_s1, m_s2, m_db;
    int          m_run [17];
    bit          m_btn_d, m_status, m_jumping;
    int          m_cyc, m_jt, m_n, m_pos;

    function automatic int model_speed();
        int s;
        if (!m_status) return 0;
        s = 1 + m_n / STEP;
        return (s > 15) ? 15 : s;
    endfunction

    function automatic int model_height();
        if (!m_jumping) return 0;
        return (m_jt <= PEAK) ? m_jt : 2 * PEAK - m_jt;
    endfunction

    function automatic logic px_model(int row, int col, int pos);
        int x;
        if (col >= 640) return 1'b0;
        x = (col + pos) % 640;
        return (row == GROW) || (row == GROW + 1) || ((row == GROW + 4) && ((x % 32) < 2));
    endfunction

    task automatic model_step();
        logic [16:0] raw;
        bit tick, press;
        raw = {bif.BTN_JUMP, bif.SW};
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0;
            for (int i = 0; i < 17; i++) m_run[i] = 0;
            m_btn_d = 0; m_status = 0; m_jumping = 0;
            m_cyc = 0; m_jt = 0; m_n = 0; m_pos = 0;
            return;
        end
        tick  = (m_cyc == TICK - 1);
        press = m_db[16] && !m_btn_d;
        if (m_status && tick) begin
            m_pos = (m_pos + model_speed()) % 640;
            m_n++;
        end
        if (m_jumping && tick) begin
            m_jt++;
            if (m_jt == 2 * PEAK) begin
                m_jumping = 0;
                m_jt = 0;
            end
        end else if (!m_jumping && press) begin
            m_jumping = 1;
            m_jt = 0;
        end
        if (press) m_status = 1;
        m_btn_d = m_db[16];
        for (int i = 0; i < 17; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == (1 << JIT)) begin
                    m_db[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
        m_cyc = (m_cyc + 1) % TICK;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bif.BTN_JUMP = 0; bif.SW = '0; bif.row_addr = '0; bif.col_addr = '0;
        rst = 1;
        repeat (3) cycle();
        rst = 0;
        cycle();
        n_cmp += 6;
        if (bif.SW_OK !== 16'h0) begin n_bad++; $display("FAIL rst_sw_ok: got %h expected 0000", bif.SW_OK); end
        if (bif.dinosaur_height !== 6'd0) begin n_bad++; $display("FAIL rst_height: got %0d expected 0", bif.dinosaur_height); end
        if (bif.game_status !== 1'b0) begin n_bad++; $display("FAIL rst_status: got %b expected 0", bif.game_status); end
        if (bif.speed !== 4'd0) begin n_bad++; $display("FAIL rst_speed: got %0d expected 0", bif.speed); end
        if (dut.position_reg !== 10'd0) begin n_bad++; $display("FAIL rst_position: got %0d expected 0", dut.position_reg); end
        if (bif.px_ground !== 1'b0) begin n_bad++; $display("FAIL rst_px: got %b expected 0", bif.px_ground); end
    endtask

    task automatic test_debounce();
        // 15-edge pulse on SW[3] is too short to pass
        bif.SW = 16'h0008;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (k == 15) bif.SW = 16'h0000;
            n_cmp += 2;
            if (bif.SW_OK[3] !== 1'b0) begin n_bad++; $display("FAIL db_short k=%0d: got %b expected 0", k, bif.SW_OK[3]); end
            if (bif.SW_OK !== m_db[15:0]) begin n_bad++; $display("FAIL db_short_model k=%0d: got %h expected %h", k, bif.SW_OK, m_db[15:0]); end
        end
        // 16-edge pulse passes, output rising at the 18th edge
        bif.SW = 16'h0008;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (k == 16) bif.SW = 16'h0000;
            n_cmp++;
            if (bif.SW_OK !== m_db[15:0]) begin n_bad++; $display("FAIL db_long_model k=%0d: got %h expected %h", k, bif.SW_OK, m_db[15:0]); end
            if (k == 17 || k == 18) begin
                n_cmp++;
                if (bif.SW_OK[3] !== (k == 18)) begin n_bad++; $display("FAIL db_edge k=%0d: got %b expected %0d", k, bif.SW_OK[3], k == 18); end
            end
        end
        // Random bouncing on all switches
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) == 0) bif.SW[$urandom_range(0, 15)] ^= 1'b1;
            cycle();
            n_cmp++;
            if (bif.SW_OK !== m_db[15:0]) begin n_bad++; $display("FAIL db_rand k=%0d: got %h expected %h", k, bif.SW_OK, m_db[15:0]); end
        end
        bif.SW = '0;
        repeat (20) cycle();
        n_cmp++;
        if (bif.SW_OK !== 16'h0) begin n_bad++; $display("FAIL db_settle: got %h expected 0000", bif.SW_OK); end
    endtask

    task automatic test_jump();
        int changes[$];
        int exp_seq[6] = '{1, 2, 3, 2, 1, 0};
        int prev_h = 0;
        bif.BTN_JUMP = 1;
        for (int k = 1; k <= 130; k++) begin
            cycle();
            n_cmp += 3;
            if (bif.game_status !== m_status) begin n_bad++; $display("FAIL jump_status k=%0d: got %b expected %0d", k, bif.game_status, m_status); end
            if (bif.dinosaur_height !== 6'(model_height())) begin n_bad++; $display("FAIL jump_height k=%0d: got %0d expected %0d", k, bif.dinosaur_height, model_height()); end
            if (bif.speed !== 4'(model_speed())) begin n_bad++; $display("FAIL jump_speed k=%0d: got %0d expected %0d", k, bif.speed, model_speed()); end
            if (k == 18 || k == 19) begin
                n_cmp++;
                if (bif.game_status !== (k == 19)) begin n_bad++; $display("FAIL start_edge k=%0d: got %b expected %0d", k, bif.game_status, k == 19); end
            end
            if (int'(bif.dinosaur_height) != prev_h) begin
                changes.push_back(int'(bif.dinosaur_height));
                prev_h = int'(bif.dinosaur_height);
            end
            if (k == 19) bif.BTN_JUMP = 0;
            if (k == 37) bif.BTN_JUMP = 1;
            if (k == 75) bif.BTN_JUMP = 0;
        end
        n_cmp++;
        if (changes.size() != 6) begin
            n_bad++; $display("FAIL jump_seq_len: got %0d expected 6", changes.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (changes[i] != exp_seq[i]) begin n_bad++; $display("FAIL jump_seq[%0d]: got %0d expected %0d", i, changes[i], exp_seq[i]); end
            end
        end
    endtask

    task automatic test_random_play();
        int wraps = 0;
        int prev_pos = int'(dut.position_reg);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 24) == 0) bif.BTN_JUMP = ~bif.BTN_JUMP;
            if ($urandom_range(0, 19) == 0) bif.SW[$urandom_range(0, 15)] ^= 1'b1;
            bif.row_addr = ($urandom_range(0, 1) == 0) ? 9'(GROW - 2 + $urandom_range(0, 7)) : 9'($urandom_range(0, 511));
            bif.col_addr = 10'($urandom_range(0, 799));
            cycle();
            n_cmp += 6;
            if (bif.SW_OK !== m_db[15:0]) begin n_bad++; $display("FAIL play_sw k=%0d: got %h expected %h", k, bif.SW_OK, m_db[15:0]); end
            if (bif.game_status !== m_status) begin n_bad++; $display("FAIL play_status k=%0d: got %b expected %0d", k, bif.game_status, m_status); end
            if (bif.dinosaur_height !== 6'(model_height())) begin n_bad++; $display("FAIL play_height k=%0d: got %0d expected %0d", k, bif.dinosaur_height, model_height()); end
            if (bif.speed !== 4'(model_speed())) begin n_bad++; $display("FAIL play_speed k=%0d: got %0d expected %0d", k, bif.speed, model_speed()); end
            if (dut.position_reg !== 10'(m_pos)) begin n_bad++; $display("FAIL play_position k=%0d: got %0d expected %0d", k, dut.position_reg, m_pos); end
            if (bif.px_ground !== px_model(int'(bif.row_addr), int'(bif.col_addr), m_pos)) begin
                n_bad++; $display("FAIL play_px k=%0d row=%0d col=%0d: got %b expected %b", k, bif.row_addr, bif.col_addr, bif.px_ground, px_model(int'(bif.row_addr), int'(bif.col_addr), m_pos));
            end
            if (int'(dut.position_reg) < prev_pos) wraps++;
            prev_pos = int'(dut.position_reg);
        end
        n_cmp += 2;
        if (bif.speed !== 4'd15) begin n_bad++; $display("FAIL speed_saturate: got %0d expected 15", bif.speed); end
        if (wraps == 0) begin n_bad++; $display("FAIL position_wrap: got %0d wraps expected >0", wraps); end
    endtask

    task automatic test_reset_mid_jump();
        int rows[8] = '{400, 404, 404, 399, 400, 401, 404, 402};
        int cols[8] = '{5, 33, 34, 0, 700, 100, 64, 0};
        logic exp_px[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bit hit = 0;
        bif.BTN_JUMP = 0; bif.SW = '0;
        repeat (60) cycle();
        bif.BTN_JUMP = 1;
        for (int k = 0; k < 200 && !hit; k++) begin
            cycle();
            if (model_height() == 2) hit = 1;
        end
        n_cmp += 2;
        if (!hit) begin n_bad++; $display("FAIL mid_jump_timeout: got no height 2 expected height 2"); end
        if (bif.dinosaur_height !== 6'd2) begin n_bad++; $display("FAIL mid_jump_height: got %0d expected 2", bif.dinosaur_height); end
        rst = 1; bif.BTN_JUMP = 0;
        cycle();
        rst = 0;
        n_cmp += 5;
        if (bif.dinosaur_height !== 6'd0) begin n_bad++; $display("FAIL mj_height: got %0d expected 0", bif.dinosaur_height); end
        if (bif.game_status !== 1'b0) begin n_bad++; $display("FAIL mj_status: got %b expected 0", bif.game_status); end
        if (bif.speed !== 4'd0) begin n_bad++; $display("FAIL mj_speed: got %0d expected 0", bif.speed); end
        if (dut.position_reg !== 10'd0) begin n_bad++; $display("FAIL mj_position: got %0d expected 0", dut.position_reg); end
        if (bif.SW_OK !== 16'h0) begin n_bad++; $display("FAIL mj_sw_ok: got %h expected 0000", bif.SW_OK); end
        for (int i = 0; i < 8; i++) begin
            bif.row_addr = 9'(rows[i]);
            bif.col_addr = 10'(cols[i]);
            #1;
            n_cmp++;
            if (bif.px_ground !== exp_px[i]) begin n_bad++; $display("FAIL px_pos0 row=%0d col=%0d: got %b expected %b", rows[i], cols[i], bif.px_ground, exp_px[i]); end
        end
        cycle();
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_jump();
        test_random_play();
        test_reset_mid_jump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
